// File: rtl/prim_ram_2p_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : prim_ram_2p_pipe
//  Purpose  : Single-clock true dual-port RAM with lane write masks, optional
//             output register, read-valid handshake and zero-fill after reset.
//  Revision : 1.0  initial release
// ============================================================================
module prim_ram_2p_pipe #(
    parameter int    WIDTH              = 32,
    parameter int    DEPTH              = 1024,
    parameter int    DATA_BITS_PER_MASK = 8,
    parameter int    OUTPUT_REG         = 0,
    parameter int    CLEAR_ON_RESET     = 0,
    parameter string MEM_INIT_FILE      = "",
    localparam int   MASK_W             = WIDTH / DATA_BITS_PER_MASK,
    localparam int   ADDR_W             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              a_req_i,
    input  logic              a_write_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [WIDTH-1:0]  a_wdata_i,
    input  logic [MASK_W-1:0] a_wmask_i,
    output logic [WIDTH-1:0]  a_rdata_o,
    output logic              a_rvalid_o,

    input  logic              b_req_i,
    input  logic              b_write_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [WIDTH-1:0]  b_wdata_i,
    input  logic [MASK_W-1:0] b_wmask_i,
    output logic [WIDTH-1:0]  b_rdata_o,
    output logic              b_rvalid_o,

    output logic              init_done_o
);

    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    if (MEM_INIT_FILE != "" && CLEAR_ON_RESET != 0) begin : g_cfg_err_init
        $error("prim_ram_2p_pipe: MEM_INIT_FILE and CLEAR_ON_RESET are mutually exclusive");
    end

    if ((WIDTH % DATA_BITS_PER_MASK) != 0) begin : g_cfg_err_width
        $error("prim_ram_2p_pipe: WIDTH must be a multiple of DATA_BITS_PER_MASK");
    end

    logic [WIDTH-1:0]  r_mem [DEPTH];
    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;

    logic              w_ready;
    logic [1:0]        w_in_range;
    logic [1:0]        w_we;
    logic [1:0]        w_rd;
    logic [ADDR_W-1:0] w_addr   [2];
    logic [WIDTH-1:0]  w_rdata  [2];
    logic [1:0]        w_rvalid;

    assign w_ready       = (r_state == ST_READY);
    assign init_done_o   = w_ready;
    assign w_addr[0]     = a_addr_i;
    assign w_addr[1]     = b_addr_i;
    assign w_in_range[0] = ({1'b0, a_addr_i} < c_DEPTH);
    assign w_in_range[1] = ({1'b0, b_addr_i} < c_DEPTH);
    // Requests arriving while the zero-fill runs are silently discarded.
    assign w_we[0]       = w_ready & a_req_i & a_write_i & w_in_range[0];
    assign w_we[1]       = w_ready & b_req_i & b_write_i & w_in_range[1];
    assign w_rd[0]       = w_ready & a_req_i & ~a_write_i;
    assign w_rd[1]       = w_ready & b_req_i & ~b_write_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_RESET_STATE;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_state <= ST_READY;
            end
        end
    end

    // Port B lanes are scheduled before port A so A wins on shared lanes.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < MASK_W; i++) begin
                if (w_we[1] && b_wmask_i[i]) begin
                    r_mem[b_addr_i][i*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK] <=
                        b_wdata_i[i*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK];
                end
                if (w_we[0] && a_wmask_i[i]) begin
                    r_mem[a_addr_i][i*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK] <=
                        a_wdata_i[i*DATA_BITS_PER_MASK +: DATA_BITS_PER_MASK];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [WIDTH-1:0] r_d1;
        logic             r_v1;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_d1 <= '0;
                r_v1 <= 1'b0;
            end else begin
                r_v1 <= w_rd[p];
                if (w_rd[p]) begin
                    r_d1 <= w_in_range[p] ? r_mem[w_addr[p]] : '0;
                end
            end
        end

        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] r_d2;
            logic             r_v2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign w_rdata[p]  = r_d2;
            assign w_rvalid[p] = r_v2;
        end else begin : g_no_out_reg
            assign w_rdata[p]  = r_d1;
            assign w_rvalid[p] = r_v1;
        end
    end

    assign a_rdata_o  = w_rdata[0];
    assign a_rvalid_o = w_rvalid[0];
    assign b_rdata_o  = w_rdata[1];
    assign b_rvalid_o = w_rvalid[1];

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_2p_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prim_ram_2p_pipe
//  Purpose  : Self-checking bench; three RAM configurations share one clock,
//             reads are scored against a queue of expected responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prim_ram_2p_pipe;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Index 0: D1024 latency 1; 1: D12 latency 2; 2: D16 clear-on-reset.
    logic        rst_n   [3];
    logic        a_req   [3];
    logic        a_we    [3];
    logic [9:0]  a_addr  [3];
    logic [31:0] a_wdata [3];
    logic [3:0]  a_wmask [3];
    wire  [31:0] a_rdata [3];
    wire         a_rvalid[3];
    logic        b_req   [3];
    logic        b_we    [3];
    logic [9:0]  b_addr  [3];
    logic [31:0] b_wdata [3];
    logic [3:0]  b_wmask [3];
    wire  [31:0] b_rdata [3];
    wire         b_rvalid[3];
    wire         done    [3];

    exp_t exp_q [6][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prim_ram_2p_pipe #(.WIDTH(32), .DEPTH(1024), .DATA_BITS_PER_MASK(8),
                       .OUTPUT_REG(0), .CLEAR_ON_RESET(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .a_req_i(a_req[0]), .a_write_i(a_we[0]), .a_addr_i(a_addr[0]),
        .a_wdata_i(a_wdata[0]), .a_wmask_i(a_wmask[0]),
        .a_rdata_o(a_rdata[0]), .a_rvalid_o(a_rvalid[0]),
        .b_req_i(b_req[0]), .b_write_i(b_we[0]), .b_addr_i(b_addr[0]),
        .b_wdata_i(b_wdata[0]), .b_wmask_i(b_wmask[0]),
        .b_rdata_o(b_rdata[0]), .b_rvalid_o(b_rvalid[0]),
        .init_done_o(done[0])
    );

    prim_ram_2p_pipe #(.WIDTH(32), .DEPTH(12), .DATA_BITS_PER_MASK(8),
                       .OUTPUT_REG(1), .CLEAR_ON_RESET(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .a_req_i(a_req[1]), .a_write_i(a_we[1]), .a_addr_i(a_addr[1][3:0]),
        .a_wdata_i(a_wdata[1]), .a_wmask_i(a_wmask[1]),
        .a_rdata_o(a_rdata[1]), .a_rvalid_o(a_rvalid[1]),
        .b_req_i(b_req[1]), .b_write_i(b_we[1]), .b_addr_i(b_addr[1][3:0]),
        .b_wdata_i(b_wdata[1]), .b_wmask_i(b_wmask[1]),
        .b_rdata_o(b_rdata[1]), .b_rvalid_o(b_rvalid[1]),
        .init_done_o(done[1])
    );

    prim_ram_2p_pipe #(.WIDTH(32), .DEPTH(16), .DATA_BITS_PER_MASK(8),
                       .OUTPUT_REG(0), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]),
        .a_req_i(a_req[2]), .a_write_i(a_we[2]), .a_addr_i(a_addr[2][3:0]),
        .a_wdata_i(a_wdata[2]), .a_wmask_i(a_wmask[2]),
        .a_rdata_o(a_rdata[2]), .a_rvalid_o(a_rvalid[2]),
        .b_req_i(b_req[2]), .b_write_i(b_we[2]), .b_addr_i(b_addr[2][3:0]),
        .b_wdata_i(b_wdata[2]), .b_wmask_i(b_wmask[2]),
        .b_rdata_o(b_rdata[2]), .b_rvalid_o(b_rvalid[2]),
        .init_done_o(done[2])
    );

    // Scoreboard: queue index = dut*2 + port (0 = A, 1 = B).
    always @(negedge clk) begin
        logic        v;
        logic [31:0] d;
        exp_t        e;
        for (int q = 0; q < 6; q++) begin
            v = (q % 2 == 0) ? a_rvalid[q/2] : b_rvalid[q/2];
            d = (q % 2 == 0) ? a_rdata[q/2]  : b_rdata[q/2];
            if (v === 1'b1) begin
                checks++;
                if (exp_q[q].size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected q=%0d cyc=%0d: got rvalid=1 data=%h, expected no response", q, cyc, d);
                end else begin
                    e = exp_q[q].pop_front();
                    if (d !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL read_data q=%0d: got %h at cyc %0d, expected %h at cyc %0d", q, d, cyc, e.d, e.due);
                    end
                end
            end else if (exp_q[q].size() != 0 && exp_q[q][0].due < cyc) begin
                e = exp_q[q].pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing q=%0d: got no rvalid by cyc %0d, expected %h at cyc %0d", q, cyc, e.d, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(int k, logic req, logic we, logic [9:0] addr, logic [31:0] wd, logic [3:0] m);
        a_req[k] = req; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = wd; a_wmask[k] = m;
    endtask

    task automatic drv_b(int k, logic req, logic we, logic [9:0] addr, logic [31:0] wd, logic [3:0] m);
        b_req[k] = req; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = wd; b_wmask[k] = m;
    endtask

    task automatic expect_read(int q, logic [31:0] d, int lat);
        exp_t e;
        e.d   = d;
        e.due = cyc + lat;
        exp_q[q].push_back(e);
    endtask

    task automatic drain();
        int pending;
        for (int n = 0; n < 6; n++) tick();
        pending = 0;
        for (int q = 0; q < 6; q++) pending += exp_q[q].size();
        checks++;
        if (pending != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", pending);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            drv_a(k, 0, 0, 0, 0, 0);
            drv_b(k, 0, 0, 0, 0, 0);
        end
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_rdata[k] !== 32'h0 || a_rvalid[k] !== 1'b0 || b_rdata[k] !== 32'h0 || b_rvalid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got a=%h/%b b=%h/%b, expected 0/0", k, a_rdata[k], a_rvalid[k], b_rdata[k], b_rvalid[k]);
            end
            checks++;
            if (done[k] !== (k != 2)) begin
                errors++;
                $display("FAIL reset_init_done dut%0d: got %b, expected %b", k, done[k], (k != 2));
            end
        end
        tick();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        for (int n = 0; n < 40 && done[2] !== 1'b1; n++) tick();
        checks++;
        if (done[2] !== 1'b1) begin
            errors++;
            $display("FAIL first_clear_timeout: got init_done=%b, expected 1 within 40 cycles", done[2]);
        end
    endtask

    task automatic test_mask();
        drv_a(0, 1, 1, 5, 32'hDEADBEEF, 4'hF); tick();
        drv_a(0, 1, 1, 5, 32'h11223344, 4'h5); tick();
        drv_a(0, 1, 0, 5, 0, 0); expect_read(0, 32'hDE22BE44, 1); tick();
        drv_a(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL rdata_hold: got %h/%b, expected DE22BE44/0", a_rdata[0], a_rvalid[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drv_a(1, 1, 1, 0, 32'hA, 4'hF); tick();
        drv_a(1, 1, 1, 1, 32'hB, 4'hF); tick();
        drv_a(1, 1, 1, 2, 32'hC, 4'hF); tick();
        drv_a(1, 1, 0, 0, 0, 0); drv_b(1, 1, 0, 2, 0, 0);
        expect_read(2, 32'hA, 2); expect_read(3, 32'hC, 2); tick();
        drv_a(1, 1, 0, 1, 0, 0); drv_b(1, 1, 0, 1, 0, 0);
        expect_read(2, 32'hB, 2); expect_read(3, 32'hB, 2); tick();
        drv_a(1, 1, 0, 2, 0, 0); drv_b(1, 1, 0, 0, 0, 0);
        expect_read(2, 32'hC, 2); expect_read(3, 32'hA, 2); tick();
        drv_a(1, 1, 1, 3, 32'hD, 4'hF); drv_b(1, 0, 0, 0, 0, 0); tick();
        drv_a(1, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_collision();
        drv_a(0, 1, 1, 7, 32'h0, 4'hF); tick();
        drv_a(0, 1, 1, 7, 32'hAAAAAAAA, 4'h3); drv_b(0, 1, 1, 7, 32'hBBBBBBBB, 4'h6); tick();
        drv_a(0, 1, 0, 7, 0, 0); drv_b(0, 1, 1, 7, 32'hFFFFFFFF, 4'hF);
        expect_read(0, 32'h00BBAAAA, 1); tick();
        drv_a(0, 1, 0, 7, 0, 0); drv_b(0, 1, 0, 7, 0, 0);
        expect_read(0, 32'hFFFFFFFF, 1); expect_read(1, 32'hFFFFFFFF, 1); tick();
        drv_a(0, 0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_out_of_range();
        drv_a(1, 1, 1, 1, 32'h12345678, 4'hF); tick();
        drv_a(1, 1, 1, 13, 32'hCAFEF00D, 4'hF); tick();
        drv_a(1, 1, 0, 13, 0, 0); drv_b(1, 1, 0, 12, 0, 0);
        expect_read(2, 32'h0, 2); expect_read(3, 32'h0, 2); tick();
        drv_a(1, 1, 0, 1, 0, 0); drv_b(1, 0, 0, 0, 0, 0);
        expect_read(2, 32'h12345678, 2); tick();
        drv_a(1, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_clear();
        for (int a = 0; a < 16; a++) begin
            drv_a(2, 1, 1, 10'(a), 32'hFF, 4'hF); tick();
        end
        drv_a(2, 1, 0, 9, 0, 0); expect_read(4, 32'hFF, 1); tick();
        drv_a(2, 0, 0, 0, 0, 0);
        drain();
        rst_n[2] = 1'b0; tick(); tick();
        rst_n[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (done[2] !== 1'b0) begin
                errors++;
                $display("FAIL clear_busy i=%0d: got init_done=%b, expected 0", i, done[2]);
            end
            if (i == 3) drv_a(2, 1, 0, 4, 0, 0);
            else        drv_a(2, 0, 0, 0, 0, 0);
        end
        tick();
        rst_n[2] = 1'b0; tick(); tick();
        rst_n[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (done[2] !== 1'b0) begin
                errors++;
                $display("FAIL clear_length i=%0d: got init_done=%b, expected 0", i, done[2]);
            end
        end
        @(negedge clk);
        checks++;
        if (done[2] !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: got init_done=%b, expected 1", done[2]);
        end
        tick();
        for (int a = 0; a < 16; a++) begin
            drv_a(2, 1, 0, 10'(a), 0, 0); expect_read(4, 32'h0, 1); tick();
        end
        drv_a(2, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_reset_inflight();
        drv_a(1, 1, 0, 0, 0, 0); tick();
        drv_a(1, 1, 0, 1, 0, 0); tick();
        rst_n[1] = 1'b0;
        drv_a(1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (a_rdata[1] !== 32'h0 || a_rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight: got %h/%b, expected 00000000/0", a_rdata[1], a_rvalid[1]);
        end
        tick(); tick();
        rst_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a_rvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_response i=%0d: got rvalid=%b, expected 0", i, a_rvalid[1]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mask();
        test_back_to_back();
        test_collision();
        test_out_of_range();
        test_clear();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
